rv_iommu_hpm_bank: RTL and testbench

RV_IOMMU_HPM_BANK -- requirements
Module: rv_iommu_hpm_bank

---
 rtl/rv_iommu_pkg.sv | 41 ++++
 rtl/rv_iommu_hpm_filter.sv | 44 ++++
 rtl/rv_iommu_hpm_bank.sv | 124 ++++++++++++
 tb/tb_rv_iommu_hpm_bank.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_iommu_pkg.sv
// Shared IOMMU definitions: event identifiers, the iohpmevt register layout
// and the register-select map of the performance-monitor bank.
package rv_iommu;

    typedef enum logic [14:0] {
        NOT_COUNT  = 15'd0,
        UT_REQ     = 15'd1,
        T_REQ      = 15'd2,
        ATS_REQ    = 15'd3,
        IOTLB_MISS = 15'd4,
        DDT_WALK   = 15'd5,
        PDT_WALK   = 15'd6,
        S1_PTW     = 15'd7,
        S2_PTW     = 15'd8
    } eventid_t;

    typedef struct packed {
        logic        of;
        logic        idt;
        logic        dv_gscv;
        logic        pv_pscv;
        logic [23:0] did_gscid;
        logic [19:0] pid_pscid;
        logic        dmask;
        logic [14:0] eventid;
    } iohpmevt_t;

    localparam int unsigned SEL_COUNTOVF = 0;
    localparam int unsigned SEL_COUNTINH = 1;
    localparam int unsigned SEL_CYCLES   = 2;
    localparam int unsigned SEL_CTR_BASE = 3;

    // DMASK is a read-zero field, so it is cleared on every software write.
    function automatic iohpmevt_t evt_from_wdata(input logic [63:0] d);
        iohpmevt_t e;
        e       = iohpmevt_t'(d);
        e.dmask = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/rv_iommu_hpm_filter.sv
// Per-counter event matcher: counts how many source channels hit the
// programmed event this cycle after applying the ID filter.
module rv_iommu_hpm_filter
    import rv_iommu::*;
#(
    parameter  int unsigned N_SRC = 2,
    localparam int unsigned CNT_W = $clog2(N_SRC + 1)
) (
    input  iohpmevt_t                  evt_i,
    input  logic [N_SRC-1:0]           evt_valid_i,
    input  logic [N_SRC-1:0][14:0]     evt_id_i,
    input  logic [N_SRC-1:0][23:0]     evt_did_i,
    input  logic [N_SRC-1:0][19:0]     evt_pid_i,
    input  logic [N_SRC-1:0]           evt_pv_i,
    input  logic [N_SRC-1:0][19:0]     evt_pscid_i,
    input  logic [N_SRC-1:0][15:0]     evt_gscid_i,
    output logic [CNT_W-1:0]           cnt_o
);

    logic unused_evt_bits;
    assign unused_evt_bits = ^{evt_i.of, evt_i.dmask};

    always_comb begin
        cnt_o = '0;
        for (int s = 0; s < int'(N_SRC); s++) begin
            logic hit;
            hit = evt_valid_i[s] && (evt_id_i[s] == evt_i.eventid) && (evt_i.eventid != NOT_COUNT);
            // IDT selects whether the tag fields compare against device/process or GSCID/PSCID.
            if (evt_i.idt) begin
                if (evt_i.pv_pscv && (evt_pscid_i[s] != evt_i.pid_pscid))
                    hit = 1'b0;
                if (evt_i.dv_gscv && (evt_gscid_i[s] != evt_i.did_gscid[15:0]))
                    hit = 1'b0;
            end else begin
                if (evt_i.pv_pscv && (!evt_pv_i[s] || (evt_pid_i[s] != evt_i.pid_pscid)))
                    hit = 1'b0;
                if (evt_i.dv_gscv && (evt_did_i[s] != evt_i.did_gscid))
                    hit = 1'b0;
            end
            cnt_o = cnt_o + CNT_W'(hit);
        end
    end

endmodule

// File: rtl/rv_iommu_hpm_bank.sv
// IOMMU hardware performance-monitor bank: cycle counter, N programmable
// event counters with filters, overflow tracking and a one-cycle interrupt.
module rv_iommu_hpm_bank
    import rv_iommu::*;
#(
    parameter  int unsigned N_IOHPMCTR = 8,
    parameter  int unsigned CTR_W      = 64,
    parameter  int unsigned N_SRC      = 2,
    localparam int unsigned SEL_W      = $clog2(3 + 2 * N_IOHPMCTR)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_SRC-1:0]           evt_valid_i,
    input  logic [N_SRC-1:0][14:0]     evt_id_i,
    input  logic [N_SRC-1:0][23:0]     evt_did_i,
    input  logic [N_SRC-1:0][19:0]     evt_pid_i,
    input  logic [N_SRC-1:0]           evt_pv_i,
    input  logic [N_SRC-1:0][19:0]     evt_pscid_i,
    input  logic [N_SRC-1:0][15:0]     evt_gscid_i,
    input  logic                       wr_en_i,
    input  logic [SEL_W-1:0]           wr_sel_i,
    input  logic [63:0]                wr_data_i,
    input  logic [SEL_W-1:0]           rd_sel_i,
    output logic [63:0]                rd_data_o,
    output logic                       hpm_irq_o
);

    localparam int unsigned CNT_W = $clog2(N_SRC + 1);
    localparam int unsigned SUM_W = CTR_W + CNT_W;

    logic [CTR_W-1:0]      ctr_q [N_IOHPMCTR];
    iohpmevt_t             evt_q [N_IOHPMCTR];
    logic [N_IOHPMCTR:0]   inh_q;
    logic [62:0]           cyc_q;
    logic                  cyc_of_q;
    logic                  irq_p1;

    logic [CNT_W-1:0]      cnt_p0 [N_IOHPMCTR];
    logic [SUM_W-1:0]      sum_p0 [N_IOHPMCTR];
    logic [N_IOHPMCTR-1:0] wr_ctr_p0, wr_evt_p0, ctr_ovf_p0, new_ovf_p0;
    logic [N_IOHPMCTR:0]   ovf_vec;
    logic                  wr_inh_p0, wr_cyc_p0, cyc_ovf_p0;

    // Stage p0: match, add and detect wrap; a write to the same counter suppresses both.
    for (genvar i = 0; i < int'(N_IOHPMCTR); i++) begin : g_ctr
        rv_iommu_hpm_filter #(.N_SRC(N_SRC)) u_filter (
            .evt_i       (evt_q[i]),
            .evt_valid_i (evt_valid_i),
            .evt_id_i    (evt_id_i),
            .evt_did_i   (evt_did_i),
            .evt_pid_i   (evt_pid_i),
            .evt_pv_i    (evt_pv_i),
            .evt_pscid_i (evt_pscid_i),
            .evt_gscid_i (evt_gscid_i),
            .cnt_o       (cnt_p0[i])
        );
        assign sum_p0[i]     = SUM_W'(ctr_q[i]) + SUM_W'(cnt_p0[i]);
        assign wr_ctr_p0[i]  = wr_en_i && (wr_sel_i == SEL_W'(SEL_CTR_BASE + i));
        assign wr_evt_p0[i]  = wr_en_i && (wr_sel_i == SEL_W'(SEL_CTR_BASE + N_IOHPMCTR + i));
        assign ctr_ovf_p0[i] = (|sum_p0[i][SUM_W-1:CTR_W]) && !wr_ctr_p0[i] && !inh_q[i+1];
        assign new_ovf_p0[i] = ctr_ovf_p0[i] && !evt_q[i].of;
        assign ovf_vec[i+1]  = evt_q[i].of;
    end

    assign ovf_vec[0]  = cyc_of_q;
    assign wr_inh_p0   = wr_en_i && (wr_sel_i == SEL_W'(SEL_COUNTINH));
    assign wr_cyc_p0   = wr_en_i && (wr_sel_i == SEL_W'(SEL_CYCLES));
    assign cyc_ovf_p0  = (&cyc_q) && !wr_cyc_p0 && !inh_q[0];

    // Stage p1: register state and the merged overflow pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(N_IOHPMCTR); i++) begin
                ctr_q[i] <= '0;
                evt_q[i] <= '0;
            end
            inh_q    <= '1;
            cyc_q    <= '0;
            cyc_of_q <= 1'b0;
            irq_p1   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N_IOHPMCTR); i++) begin
                if (wr_ctr_p0[i])
                    ctr_q[i] <= wr_data_i[CTR_W-1:0];
                else if (!inh_q[i+1])
                    ctr_q[i] <= sum_p0[i][CTR_W-1:0];
                if (wr_evt_p0[i])
                    evt_q[i] <= evt_from_wdata(wr_data_i);
                else if (ctr_ovf_p0[i])
                    evt_q[i].of <= 1'b1;
            end
            if (wr_inh_p0)
                inh_q <= wr_data_i[N_IOHPMCTR:0];
            if (wr_cyc_p0) begin
                cyc_q    <= wr_data_i[62:0];
                cyc_of_q <= wr_data_i[63];
            end else if (!inh_q[0]) begin
                cyc_q <= cyc_q + 63'd1;
                if (cyc_ovf_p0)
                    cyc_of_q <= 1'b1;
            end
            irq_p1 <= (|new_ovf_p0) || (cyc_ovf_p0 && !cyc_of_q);
        end
    end

    assign hpm_irq_o = irq_p1;

    always_comb begin
        rd_data_o = '0;
        if (rd_sel_i == SEL_W'(SEL_COUNTOVF))
            rd_data_o[N_IOHPMCTR:0] = ovf_vec;
        else if (rd_sel_i == SEL_W'(SEL_COUNTINH))
            rd_data_o[N_IOHPMCTR:0] = inh_q;
        else if (rd_sel_i == SEL_W'(SEL_CYCLES))
            rd_data_o = {cyc_of_q, cyc_q};
        for (int i = 0; i < int'(N_IOHPMCTR); i++) begin
            if (rd_sel_i == SEL_W'(SEL_CTR_BASE + i))
                rd_data_o[CTR_W-1:0] = ctr_q[i];
            if (rd_sel_i == SEL_W'(SEL_CTR_BASE + N_IOHPMCTR + i))
                rd_data_o = evt_q[i];
        end
    end

endmodule

// File: tb/tb_rv_iommu_hpm_bank.sv
// Directed plus randomized bench for rv_iommu_hpm_bank, checked against a
// register-level reference model of the performance-monitor bank.
module tb_rv_iommu_hpm_bank;

    localparam int N = 8;
    localparam int S = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [S-1:0]       evt_valid;
    logic [S-1:0][14:0] evt_id;
    logic [S-1:0][23:0] evt_did;
    logic [S-1:0][19:0] evt_pid;
    logic [S-1:0]       evt_pv;
    logic [S-1:0][19:0] evt_pscid;
    logic [S-1:0][15:0] evt_gscid;
    logic               wr_en;
    logic [4:0]         wr_sel;
    logic [63:0]        wr_data;
    logic [4:0]         rd_sel;
    logic [63:0]        rd_data;
    logic               irq;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_ctr [N];
    logic [63:0] m_evt [N];
    logic [N:0]  m_inh;
    logic [62:0] m_cyc;
    logic        m_cyc_of;
    logic        m_irq;

    rv_iommu_hpm_bank #(.N_IOHPMCTR(N), .CTR_W(64), .N_SRC(S)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .evt_valid_i (evt_valid),
        .evt_id_i    (evt_id),
        .evt_did_i   (evt_did),
        .evt_pid_i   (evt_pid),
        .evt_pv_i    (evt_pv),
        .evt_pscid_i (evt_pscid),
        .evt_gscid_i (evt_gscid),
        .wr_en_i     (wr_en),
        .wr_sel_i    (wr_sel),
        .wr_data_i   (wr_data),
        .rd_sel_i    (rd_sel),
        .rd_data_o   (rd_data),
        .hpm_irq_o   (irq)
    );

    always #50 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_ctr[i] = '0;
            m_evt[i] = '0;
        end
        m_inh = '1; m_cyc = '0; m_cyc_of = 1'b0; m_irq = 1'b0;
    endtask

    // Event filter rules written directly from the register field layout.
    function automatic bit chan_match(int i, int s);
        logic [63:0] e;
        logic [14:0] eid;
        e = m_evt[i];
        eid = e[14:0];
        if (!evt_valid[s] || evt_id[s] != eid || eid == 15'd0) return 0;
        if (e[62]) begin
            if (e[60] && evt_pscid[s] != e[35:16]) return 0;
            if (e[61] && evt_gscid[s] != e[51:36]) return 0;
        end else begin
            if (e[60] && (!evt_pv[s] || evt_pid[s] != e[35:16])) return 0;
            if (e[61] && evt_did[s] != e[59:36]) return 0;
        end
        return 1;
    endfunction

    function automatic logic [63:0] exp_read(int sel);
        logic [63:0] r;
        r = '0;
        if (sel == 0) begin
            r[0] = m_cyc_of;
            for (int i = 0; i < N; i++) r[i+1] = m_evt[i][63];
        end else if (sel == 1) r[N:0] = m_inh;
        else if (sel == 2) r = {m_cyc_of, m_cyc};
        else if (sel >= 3 && sel < 3 + N) r = m_ctr[sel-3];
        else if (sel >= 3 + N && sel < 3 + 2 * N) r = m_evt[sel-3-N];
        return r;
    endfunction

    // Advance one clock: compute the model's next state from the driven inputs.
    task automatic tick();
        logic [63:0] n_ctr [N];
        logic [63:0] n_evt [N];
        logic [N:0]  n_inh;
        logic [62:0] n_cyc;
        logic        n_cof;
        logic        n_irq;
        logic [64:0] sum;
        int          cnt;
        int          ws;
        ws = int'(wr_sel);
        n_irq = 1'b0; n_inh = m_inh; n_cyc = m_cyc; n_cof = m_cyc_of;
        for (int i = 0; i < N; i++) begin
            n_ctr[i] = m_ctr[i];
            n_evt[i] = m_evt[i];
            cnt = 0;
            for (int s = 0; s < S; s++) if (chan_match(i, s)) cnt++;
            if (wr_en && ws == 3 + i) n_ctr[i] = wr_data;
            else if (!m_inh[i+1]) begin
                sum = {1'b0, m_ctr[i]} + 65'(cnt);
                n_ctr[i] = sum[63:0];
                if (sum[64]) begin
                    n_evt[i][63] = 1'b1;
                    if (!m_evt[i][63]) n_irq = 1'b1;
                end
            end
            if (wr_en && ws == 3 + N + i) begin
                n_evt[i] = wr_data;
                n_evt[i][15] = 1'b0;
            end
        end
        if (wr_en && ws == 1) n_inh = wr_data[N:0];
        if (wr_en && ws == 2) {n_cof, n_cyc} = wr_data;
        else if (!m_inh[0]) begin
            if (m_cyc == '1) begin
                n_cof = 1'b1;
                if (!m_cyc_of) n_irq = 1'b1;
            end
            n_cyc = m_cyc + 63'd1;
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            m_ctr[i] = n_ctr[i];
            m_evt[i] = n_evt[i];
        end
        m_inh = n_inh; m_cyc = n_cyc; m_cyc_of = n_cof; m_irq = n_irq;
        #1;
    endtask

    task automatic chk_val(input int sel, input logic [63:0] exp, input string tag);
        rd_sel = 5'(sel);
        #1;
        checks++;
        assert (rd_data === exp) else begin
            errors++;
            $error("FAIL %s sel=%0d observed=%h expected=%h", tag, sel, rd_data, exp);
        end
    endtask

    task automatic chk(input int sel, input string tag);
        chk_val(sel, exp_read(sel), tag);
    endtask

    task automatic chk_irq(input string tag);
        checks++;
        assert (irq === m_irq) else begin
            errors++;
            $error("FAIL %s irq observed=%b expected=%b", tag, irq, m_irq);
        end
    endtask

    task automatic dump_all(input string tag);
        for (int sel = 0; sel < 3 + 2 * N + 1; sel++) chk(sel, tag);
        chk(31, tag);
        chk_irq(tag);
    endtask

    task automatic idle();
        evt_valid = '0; evt_id = '0; evt_did = '0; evt_pid = '0;
        evt_pv = '0; evt_pscid = '0; evt_gscid = '0;
    endtask

    task automatic wr(input int sel, input logic [63:0] d);
        wr_en = 1'b1; wr_sel = 5'(sel); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic ev(input int s, input logic [14:0] id, input logic [23:0] did);
        evt_valid[s] = 1'b1; evt_id[s] = id; evt_did[s] = did;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0; rd_sel = '0;
        idle();
        model_reset();
        @(posedge clk); #1;
        dump_all("reset");
        chk_val(1, 64'h1FF, "reset_inh_all_ones");
        rst_n = 1'b1;

        // Release inhibit, count five IOTLB misses on one channel.
        wr(1, 64'h0);
        wr(3 + N, 64'd4);
        for (int k = 0; k < 5; k++) begin
            idle(); ev(0, 15'd4, 24'h0);
            tick();
        end
        idle(); tick();
        chk_val(3, 64'd5, "iotlb_miss_5");
        chk(2, "cycles_run");

        // Both channels in one cycle, then NOT_COUNT on both.
        wr(3 + N + 1, 64'd1);
        idle(); ev(0, 15'd1, 24'h0); ev(1, 15'd1, 24'h0);
        tick();
        chk_val(4, 64'd2, "ut_req_dual");
        idle(); ev(0, 15'd0, 24'h0); ev(1, 15'd0, 24'h0);
        tick();
        chk_val(4, 64'd2, "not_count_ut");
        chk_val(6, 64'd0, "not_count_idle_ctr");

        // Device-ID filter: only did 0x42 counted.
        idle();
        wr(3 + N + 2, {2'b00, 1'b1, 1'b0, 24'h42, 20'h0, 1'b1, 15'd4});
        chk_val(3 + N + 2, {2'b00, 1'b1, 1'b0, 24'h42, 20'h0, 1'b0, 15'd4}, "evt_dmask_rz");
        ev(0, 15'd4, 24'h42); ev(1, 15'd4, 24'h43);
        tick();
        chk_val(5, 64'd1, "did_filter");
        chk_val(3, 64'd7, "no_filter_both");

        // Wrap with OF clear pulses once; second wrap with OF set is silent.
        idle();
        wr(3, 64'hFFFF_FFFF_FFFF_FFFF);
        ev(0, 15'd4, 24'h0);
        tick();
        chk_val(3, 64'd0, "wrap_ctr");
        chk_val(0, 64'h2, "wrap_ovf_bit1");
        chk_irq("wrap_irq_pulse");
        idle(); tick();
        chk_irq("wrap_irq_single");
        wr(3, 64'hFFFF_FFFF_FFFF_FFFF);
        ev(0, 15'd4, 24'h0);
        tick();
        chk_val(3, 64'd0, "wrap2_ctr");
        chk_irq("wrap2_no_irq");
        chk(3 + N, "wrap2_of_kept");

        // Write precedence over a same-cycle increment.
        ev(0, 15'd4, 24'h0);
        wr(3, 64'd10);
        idle();
        chk_val(3, 64'd10, "write_precedence");
        chk_irq("write_no_irq");
        wr(3 + N, 64'd4);
        chk(0, "of_cleared");

        // Randomized traffic with filtered counters.
        for (int i = 3; i < N; i++)
            wr(3 + N + i, {1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 24'h42,
                           (($urandom % 2) != 0) ? 20'h11 : 20'h7, 1'b0,
                           (($urandom % 2) != 0) ? 15'd1 : 15'd4});
        for (int c = 0; c < 300; c++) begin
            for (int s = 0; s < S; s++) begin
                evt_valid[s] = 1'($urandom);
                evt_id[s]    = (($urandom % 4) == 0) ? 15'($urandom % 6) : ((($urandom % 2) != 0) ? 15'd1 : 15'd4);
                evt_did[s]   = (($urandom % 2) != 0) ? 24'h42 : 24'h43;
                evt_pid[s]   = (($urandom % 2) != 0) ? 20'h11 : 20'h12;
                evt_pv[s]    = 1'($urandom);
                evt_pscid[s] = (($urandom % 2) != 0) ? 20'h7 : 20'h8;
                evt_gscid[s] = (($urandom % 2) != 0) ? 16'h42 : 16'h99;
            end
            if (($urandom % 8) == 0) begin
                wr_en = 1'b1;
                wr_sel = 5'(3 + ($urandom % N));
                case ($urandom % 3)
                    0: wr_data = {$urandom, $urandom};
                    1: wr_data = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom % 3);
                    default: wr_data = 64'($urandom % 16);
                endcase
                if (($urandom % 10) == 0) begin
                    wr_sel = 5'd1;
                    wr_data = 64'($urandom % 4);
                end
                if (($urandom % 10) == 0) begin
                    wr_sel = 5'(3 + N + ($urandom % N));
                    wr_data = {1'($urandom), 3'($urandom), 24'h42, 20'h11, 1'b1, 15'd4};
                end
            end
            tick();
            wr_en = 1'b0;
            chk_irq("rand_irq");
            chk(int'($urandom % 32), "rand_read");
            if ((c % 25) == 24) dump_all("rand_dump");
        end

        // Reset mid-count with an interrupt pulse in flight.
        idle();
        wr(1, 64'h0);
        wr(3 + N, 64'd4);
        wr(3, 64'hFFFF_FFFF_FFFF_FFFF);
        ev(0, 15'd4, 24'h0);
        tick();
        chk_irq("pre_reset_irq");
        rst_n = 1'b0;
        #1;
        model_reset();
        dump_all("mid_reset");
        @(posedge clk); #1;
        dump_all("held_reset");
        rst_n = 1'b1;
        tick();
        chk_val(3, 64'd0, "post_reset_inhibited");
        chk_val(2, 64'd0, "post_reset_cycles");
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
